// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch queue
package fetch_pkg;

  localparam int FETCH_WORD_W = 32;
  localparam int PC_STEP      = FETCH_WORD_W / 8;

  typedef logic [FETCH_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  pred;
  } fetch_entry_t;

  typedef struct packed {
    logic  valid;
    word_t tag;
    word_t target;
  } btb_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - cache, decode, redirect and predictor-update signals of the fetch queue
interface fetch_queue_unit_if #(
  parameter int WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic [WORD_W-1:0] imemload;
  logic              ihit;

  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_npc;
  logic              out_pred_taken;

  logic              upd_en;
  logic [WORD_W-1:0] upd_pc;
  logic [WORD_W-1:0] upd_target;
  logic              upd_taken;

  modport master (
    output imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, out_pred_taken,
    input  imemload, ihit, redirect, redirect_pc, halt, out_ready,
    input  upd_en, upd_pc, upd_target, upd_taken
  );

  modport slave (
    input  imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, out_pred_taken,
    output imemload, ihit, redirect, redirect_pc, halt, out_ready,
    output upd_en, upd_pc, upd_target, upd_taken
  );
endinterface

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer, built only when FETCH_BTB_EN is defined
`ifdef FETCH_BTB_EN
module fetch_btb #(
  parameter int WORD_W  = 32,
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              hit,
  output logic [WORD_W-1:0] target,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_taken
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - 2 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WORD_W-1:0]  tgt_q [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;

  assign l_idx = lookup_pc[2 +: IDX_W];
  assign l_tag = lookup_pc[WORD_W-1 -: TAG_W];
  assign u_idx = upd_pc[2 +: IDX_W];
  assign u_tag = upd_pc[WORD_W-1 -: TAG_W];

  // Reads see the pre-update contents when lookup and update share an index.
  assign hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign target = tgt_q[l_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
      end else if (tag_q[u_idx] == u_tag) begin
        valid_q[u_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end
endmodule
`endif

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch front end with DEPTH-entry instruction queue; optional BTB via FETCH_BTB_EN
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              WORD_W      = 32,
  parameter int              DEPTH       = 4,
  parameter logic [WORD_W-1:0] PC_INIT   = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input logic               CLK,
  input logic               RST,
  fetch_queue_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [WORD_W-1:0] STEP = WORD_W'(WORD_W / 8);

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] npc;
    logic              pred;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  fetch_state_t      state, state_n;
  logic [WORD_W-1:0] fetch_pc, next_pc;
  logic [CNT_W-1:0]  count, count_n;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              push, pop, pred, valid;

`ifdef FETCH_BTB_EN
  logic              btb_hit;
  logic [WORD_W-1:0] btb_target;

  fetch_btb #(
    .WORD_W  (WORD_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (CLK),
    .rst        (RST),
    .lookup_pc  (fetch_pc),
    .hit        (btb_hit),
    .target     (btb_target),
    .upd_en     (bus.upd_en),
    .upd_pc     (bus.upd_pc),
    .upd_target (bus.upd_target),
    .upd_taken  (bus.upd_taken)
  );

  assign pred    = btb_hit;
  assign next_pc = btb_hit ? btb_target : fetch_pc + STEP;
`else
  logic unused_upd;

  assign unused_upd = ^{bus.upd_en, bus.upd_pc, bus.upd_target, bus.upd_taken};
  assign pred       = 1'b0;
  assign next_pc    = fetch_pc + STEP;
`endif

  // Redirect wins over both the same-cycle hit and the same-cycle pop.
  assign valid = (count != '0);
  assign push  = (state == FETCH) && bus.ihit && !bus.redirect;
  assign pop   = valid && bus.out_ready && !bus.redirect;

  always_comb begin
    count_n = count;
    state_n = state;
    if (push && !pop) begin
      count_n = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_n = count - CNT_W'(1);
    end
    if (bus.redirect) begin
      count_n = '0;
    end
    if ((state == HALTED) || bus.halt) begin
      state_n = HALTED;
    end else if (count_n == CNT_W'(DEPTH)) begin
      state_n = FULL;
    end else begin
      state_n = FETCH;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FETCH;
      fetch_pc <= PC_INIT;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) begin
          fetch_pc <= next_pc;
          wr_ptr   <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: bus.imemload, pc: fetch_pc, npc: fetch_pc + STEP, pred: pred};
    end
  end

  // Head fields are zeroed while empty so stale storage never reaches decode.
  assign head               = mem[rd_ptr];
  assign bus.imemREN        = (state == FETCH);
  assign bus.imemaddr       = fetch_pc;
  assign bus.out_valid      = valid;
  assign bus.out_instr      = valid ? head.instr : '0;
  assign bus.out_pc         = valid ? head.pc    : '0;
  assign bus.out_npc        = valid ? head.npc   : '0;
  assign bus.out_pred_taken = valid ? head.pred  : 1'b0;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  fetch_queue_unit_if #(.WORD_W(32)) bus ();

  fetch_queue_unit #(
    .WORD_W      (32),
    .DEPTH       (4),
    .PC_INIT     (32'h0),
    .BTB_ENTRIES (16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], 16'hBEEF} ^ 32'h0101_0000;
  endfunction

  assign bus.imemload = mem_word(bus.imemaddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pops;

    bus.ihit = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
    bus.out_ready = 1'b0; bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
    bus.upd_taken = 1'b0;

    tick();
    check("rst_ren", 32'(bus.imemREN), 32'd1);
    check("rst_addr", bus.imemaddr, 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.out_instr, 32'h0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_npc", bus.out_npc, 32'h0);
    check("rst_pred", 32'(bus.out_pred_taken), 32'd0);

    // Streaming: hit and accept every cycle.
    rst = 1'b0; bus.ihit = 1'b1; bus.out_ready = 1'b1;
    tick();
    check("stream_valid", 32'(bus.out_valid), 32'd1);
    check("stream_pc0", bus.out_pc, 32'h0);
    check("stream_npc0", bus.out_npc, 32'h4);
    check("stream_instr0", bus.out_instr, mem_word(32'h0));
    check("stream_addr0", bus.imemaddr, 32'h4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("stream_pc", bus.out_pc, 32'(4 * k));
      check("stream_npc", bus.out_npc, 32'(4 * k + 4));
      check("stream_addr", bus.imemaddr, 32'(4 * k + 4));
    end

    // Fill to FULL with decode stalled.
    do_reset();
    bus.ihit = 1'b1; bus.out_ready = 1'b0;
    tick(); tick(); tick();
    check("fill3_ren", 32'(bus.imemREN), 32'd1);
    check("fill3_addr", bus.imemaddr, 32'hC);
    tick();
    check("full_ren", 32'(bus.imemREN), 32'd0);
    check("full_addr", bus.imemaddr, 32'h10);
    check("full_head", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("unfull_ren", 32'(bus.imemREN), 32'd1);
    check("unfull_addr", bus.imemaddr, 32'h10);
    check("unfull_head", bus.out_pc, 32'h4);

    // Redirect with 3 queued and a same-cycle hit.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    check("redir_valid", 32'(bus.out_valid), 32'd0);
    check("redir_addr", bus.imemaddr, 32'h100);
    check("redir_ren", 32'(bus.imemREN), 32'd1);
    tick();
    check("redir_pc", bus.out_pc, 32'h100);
    check("redir_instr", bus.out_instr, mem_word(32'h100));
    tick();

    // Halt with 2 entries queued.
    bus.ihit = 1'b0; bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("halt_ren", 32'(bus.imemREN), 32'd0);
    check("halt_head0", bus.out_pc, 32'h100);
    bus.out_ready = 1'b1;
    tick();
    check("halt_head1", bus.out_pc, 32'h104);
    check("halt_valid1", 32'(bus.out_valid), 32'd1);
    tick();
    check("halt_drained", 32'(bus.out_valid), 32'd0);
    bus.ihit = 1'b1;
    tick();
    check("halt_sticky_ren", 32'(bus.imemREN), 32'd0);
    check("halt_sticky_valid", 32'(bus.out_valid), 32'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    check("halt_redir_ren", 32'(bus.imemREN), 32'd0);
    check("halt_redir_addr", bus.imemaddr, 32'h200);
    tick();
    check("halt_redir_valid", 32'(bus.out_valid), 32'd0);

    // Random hit/ready traffic with an in-order scoreboard.
    do_reset();
    exp_pc = 32'h0;
    pops   = 0;
    for (int c = 0; c < 120; c++) begin
      bus.ihit      = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        check("rand_pc", bus.out_pc, exp_pc);
        check("rand_npc", bus.out_npc, exp_pc + 32'd4);
        check("rand_instr", bus.out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick();
    end
    check("rand_wrapped", 32'(pops >= 9), 32'd1);
    bus.ihit = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) begin
        check("drain_pc", bus.out_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("drain_addr", bus.imemaddr, exp_pc);

`ifdef FETCH_BTB_EN
    do_reset();
    bus.ihit = 1'b0; bus.out_ready = 1'b0;
    bus.upd_en = 1'b1; bus.upd_pc = 32'h8; bus.upd_target = 32'h40; bus.upd_taken = 1'b1;
    tick();
    bus.upd_en = 1'b0; bus.ihit = 1'b1;
    tick(); tick(); tick();
    check("btb_addr", bus.imemaddr, 32'h40);
    bus.ihit = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("btb_pc4", bus.out_pc, 32'h4);
    check("btb_pred4", 32'(bus.out_pred_taken), 32'd0);
    tick();
    check("btb_pc8", bus.out_pc, 32'h8);
    check("btb_pred8", 32'(bus.out_pred_taken), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined MIPS core; replaces the single-entry PC-plus-IF/ID fetch path.
- Drives the instruction-cache request and buffers up to DEPTH fetched instructions with their PC and PC+4.
- Presents instructions to decode through a valid/ready handshake.
- Accepts redirects (branch/jump resolution) that flush the queue, and a halt that stops fetch permanently.

Parameters:
WORD_W, 32, instruction/address width in bits; PC step is WORD_W/8
DEPTH, 4, queue entries; power of two, >= 2
PC_INIT, 0, fetch PC after reset
BTB_ENTRIES, 16, direct-mapped predictor entries (power of two; used only with FETCH_BTB_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
imemREN  out  1  fetch request
imemaddr  out  WORD_W  fetch address
imemload  in  WORD_W  fetched instruction, valid when ihit=1
ihit  in  1  cache returns imemload for imemaddr this cycle
redirect  in  1  flush queue and restart fetch
redirect_pc  in  WORD_W  restart address
halt  in  1  stop fetching (sticky)
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
out_instr  out  WORD_W  head instruction
out_pc  out  WORD_W  head PC
out_npc  out  WORD_W  head PC+step
out_pred_taken  out  1  head fetched on predicted-taken path
upd_en  in  1  predictor update strobe
upd_pc  in  WORD_W  branch PC
upd_target  in  WORD_W  resolved target
upd_taken  in  1  resolved direction

Behaviour:
- Reset (async, RST=1):
  - fetch_pc=PC_INIT, count=0, rd/wr pointers=0, state=FETCH.
  - Outputs: imemREN=1, imemaddr=PC_INIT, out_valid=0, out_instr/out_pc/out_npc=0, out_pred_taken=0.
  - Reset mid-miss abandons the request; no entry is written.
- FSM states and transitions:
  - FETCH: imemREN=1, imemaddr=fetch_pc.
  - FETCH -> FULL when a push makes count==DEPTH without a pop.
  - FULL: imemREN=0; moves to FETCH when count<DEPTH.
  - HALTED: imemREN=0 forever; leaves only on reset.
- Push: in FETCH with ihit=1 and no redirect, write {imemload, fetch_pc, fetch_pc+step, pred} at wr_ptr and advance fetch_pc to next_pc.
  - next_pc = fetch_pc+step, or the predicted target (see Optional Feature).
- Address stability: imemaddr holds stable while imemREN=1 until ihit or redirect.
- Pop: out_valid=(count!=0); out_* are the head entry, combinational from storage; out_valid&out_ready advances rd_ptr.
- Latency: an instruction hit in cycle N is visible on out_* in cycle N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Count width is clog2(DEPTH+1); pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Redirect (highest priority):
  - Next cycle: count=0, pointers=0, fetch_pc=redirect_pc.
  - Any same-cycle ihit data and pop are discarded; out_valid drops the following cycle.
  - If already HALTED, the flush still occurs but fetch does not resume.
- Halt: halt=1 forces HALTED next cycle and imemREN=0. Entries already queued remain poppable. Halt together with redirect: flush and halt.
- PC arithmetic wraps modulo 2^WORD_W with no overflow flag; the low two address bits pass through unchecked.

Optional Feature:
FETCH_BTB_EN
- Defined:
  - A direct-mapped BTB of BTB_ENTRIES, indexed by pc[2+:log2(BTB_ENTRIES)], each entry {valid, tag, target}.
  - Lookup is combinational on fetch_pc. On a tag match with valid=1, next_pc=target and the entry is pushed with pred=1.
  - upd_en with upd_taken=1 writes {1, tag, upd_target}; upd_en with upd_taken=0 clears a matching entry.
  - Reset clears all valid bits.
  - Update and lookup at the same index in the same cycle: lookup sees the old contents.
- Undefined: next_pc is always fetch_pc+step, out_pred_taken is tied to 0, upd_* are ignored, and no BTB storage is generated.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {FETCH, FULL, HALTED}
  - fetch_entry_t packed struct {instr, pc, npc, pred}
  - btb_entry_t
  - localparam PC_STEP
- Reuses word_t from cpu_types_pkg where WORD_W=32.
- One sub-module, fetch_btb (lookup/update), instantiated under FETCH_BTB_EN.

Test Plan:
- Reset, ihit held 1, out_ready=1 -> imemaddr 0,4,8,...; out_pc 0 appears one cycle after the first ihit; out_npc=out_pc+4.
- out_ready=0, ihit=1 -> four entries PCs 0..12 pushed, then imemREN=0 (FULL). Pop one -> imemREN=1, next fetch addr 16.
- Queue holding 3 entries plus redirect=1 with redirect_pc=0x100 and ihit=1 in the same cycle -> out_valid=0 next cycle; next imemaddr=0x100; hit data discarded.
- halt=1 with 2 entries queued -> imemREN=0 from next cycle on; both entries still pop in order; then out_valid stays 0.
- Continuous fetch with the pointers wrapping at least twice and random out_ready -> no loss or duplication; out_pc strictly sequential.
- FETCH_BTB_EN: upd_en, upd_pc=0x8, upd_target=0x40, upd_taken=1 -> the fetch of 0x8 is followed by a fetch of 0x40; the 0x8 entry pops with out_pred_taken=1.
